// File: rtl/rom_stream_writer.sv
// Packs the ROM-loading byte stream into 16-bit LE words, buffers them and writes them to SDRAM.
// Optional GBA header capture is enabled by defining ROMWRITER_HEADER_EN.
module rom_stream_writer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [22:0] ROM_BASE   = 23'h000000,
  parameter logic [22:0] CRAM_BASE  = 23'h700000,
  parameter logic [22:0] BIOS_BASE  = 23'h780000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  rom_loading,
  input  logic [7:0]  rom_do,
  input  logic        rom_do_valid,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [22:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [23:0] load_size,
  output logic [31:0] game_code,
  output logic        hdr_valid
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  logic [1:0]  rst_sync;
  logic        rst_n_i;
  state_t      state;
  logic [2:0]  load_type;
  logic [22:0] base;
  logic [23:0] offset;
  logic [7:0]  pack_lo;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [40:0] fifo_mem [FIFO_DEPTH];
  logic [40:0] head, push_word;
  logic [22:0] word_addr;
  logic        full, pop, can_push, byte_in, push_en;

  // Reset asserts asynchronously, releases two clocks after resetn rises.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync <= '0;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_i = rst_sync[1];

  assign head      = fifo_mem[rd_ptr[AW-1:0]];
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign mem_req   = (wr_ptr != rd_ptr);
  assign pop       = mem_req && mem_ack;
  assign can_push  = !full || pop;
  assign byte_in   = (state == LOAD) && rom_do_valid && (rom_loading == load_type);
  assign word_addr = base + {offset[22:1], 1'b0};
  assign mem_addr  = mem_req ? head[40:18] : '0;
  assign mem_wdata = mem_req ? head[17:2]  : '0;
  assign mem_be    = mem_req ? head[1:0]   : '0;

  always_comb begin
    push_en   = 1'b0;
    push_word = {word_addr, 8'h00, pack_lo, 2'b01};
    if (byte_in && offset[0]) begin
      push_en   = can_push;
      push_word = {word_addr, rom_do, pack_lo, 2'b11};
    end else if (state == FLUSH && offset[0]) begin
      push_en   = can_push;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) fifo_mem[wr_ptr[AW-1:0]] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      load_type <= '0;
      base      <= '0;
      offset    <= '0;
      pack_lo   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      load_size <= '0;
`ifdef ROMWRITER_HEADER_EN
      game_code <= '0;
      hdr_valid <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case (state)
        IDLE: begin
          if (rom_loading == 3'd1 || rom_loading == 3'd2 || rom_loading == 3'd4) begin
            state     <= LOAD;
            load_type <= rom_loading;
            base      <= (rom_loading == 3'd1) ? ROM_BASE :
                         (rom_loading == 3'd2) ? CRAM_BASE : BIOS_BASE;
            offset    <= '0;
            pack_lo   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            load_size <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b1;
`ifdef ROMWRITER_HEADER_EN
            hdr_valid <= 1'b0;
`endif
          end
        end
        LOAD: begin
          // Any change of type ends this load; a new nonzero type restarts from IDLE after drain.
          if (rom_loading != load_type) begin
            state <= FLUSH;
          end else if (rom_do_valid) begin
            offset <= offset + 1'b1;
            if (load_size != '1) load_size <= load_size + 1'b1;
            if (!offset[0])     pack_lo  <= rom_do;
            else if (!can_push) overflow <= 1'b1;
`ifdef ROMWRITER_HEADER_EN
            if (load_type == 3'd1 && offset[23:2] == 22'h2B) begin
              game_code[8*offset[1:0] +: 8] <= rom_do;
              if (offset[1:0] == 2'b11) hdr_valid <= 1'b1;
            end
`endif
          end
        end
        FLUSH: begin
          if (!offset[0] || can_push) state <= DRAIN;
        end
        DRAIN: begin
          if (!mem_req) begin
            state <= IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef ROMWRITER_HEADER_EN
  assign game_code = '0;
  assign hdr_valid = 1'b0;
`endif

endmodule

// File: doc/rom_stream_writer.md
# rom_stream_writer

Downstream consumer of the I/O system's ROM-loading byte stream (`rom_loading`, `rom_do`, `rom_do_valid`). It packs the bytes into 16-bit little-endian words and buffers them in a small FIFO. It drains that FIFO to the SDRAM arbiter through a req/ack write port, placing each load type at its own base address. It also reports the loaded size, completion and overflow, and can optionally capture GBA header fields.

## Interface
- `FIFO_DEPTH`, 8: word FIFO depth; power of two, ≥ 4.
- `ROM_BASE`, 23'h000000: byte base address for `rom_loading`=1 (cart ROM).
- `CRAM_BASE`, 23'h700000: byte base address for `rom_loading`=2 (cart RAM).
- `BIOS_BASE`, 23'h780000: byte base address for `rom_loading`=4 (BIOS).
- `clk`  in  1: system clock, same domain as the I/O system.
- `resetn`  in  1: reset; asynchronous assert, active-low.
- `rom_loading`  in  3: load type. 0 idle, 1 ROM, 2 cart RAM, 3 config, 4 BIOS.
- `rom_do`  in  8: stream byte.
- `rom_do_valid`  in  1: one-cycle strobe per byte.
- `mem_req`  out  1: write request; held until acked.
- `mem_ack`  in  1: one-cycle pulse when the write completes.
- `mem_addr`  out  23: byte address, always even.
- `mem_wdata`  out  16: write data.
- `mem_be`  out  2: byte enables.
- `busy`  out  1: a load is active, or the FIFO/pending word is not yet drained.
- `done`  out  1: one-cycle pulse when a load completes.
- `overflow`  out  1: sticky flag; cleared at the start of a load.
- `load_size`  out  24: bytes received in the current or last load.
- `game_code`  out  32: header bytes 0xAC–0xAF, little-endian.
- `hdr_valid`  out  1: `game_code` has been captured.

## Operation
- States: IDLE, LOAD, FLUSH, DRAIN.
- IDLE → LOAD when `rom_loading` ∈ {1,2,4}. On entry:
  - latch the base address for that type;
  - clear `load_size`, `overflow`, `hdr_valid`, the pack register and the FIFO.
- Types 3 and 5–7: no effect; stay in IDLE; bytes are ignored.
- LOAD, each `rom_do_valid`:
  - the byte at even offset goes to the pack low byte;
  - the byte at odd offset completes a word, which is pushed with `mem_be`=2'b11 and address `base + offset - 1`;
  - `load_size` increments for every byte, including dropped ones.
- FIFO full at push time:
  - the word is dropped and `overflow` is set;
  - the offset still advances, so later addresses stay correct.
- LOAD → FLUSH when `rom_loading` returns to 0. A change to a different nonzero type is treated as 0 followed by the new load, after this load's drain.
- FLUSH:
  - if `load_size` is odd, push the pending byte with `mem_be`=2'b01, waiting one cycle if the FIFO is full;
  - then go to DRAIN.
- DRAIN → IDLE when the FIFO is empty and no request is outstanding. `done` pulses on that transition.
- Write port:
  - `mem_req` asserts whenever the FIFO is non-empty;
  - addr/data/be come from the FIFO head and are stable while `mem_req` is high;
  - `mem_ack` pops the head;
  - `mem_req` may stay high back-to-back for the next entry.
- Simultaneous push and pop on a full FIFO: the push succeeds. The pop is evaluated first.
- `mem_ack` without `mem_req` is ignored.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- Deassertion of `resetn` is synchronised internally.
- Byte → FIFO push: the cycle after the odd byte's strobe.
- Push → `mem_req`: 1 cycle if the FIFO was empty.
- Sustained input rate: one byte per cycle. This covers the I/O system's worst case of 4 bytes in 4 consecutive cycles.
- `busy` rises the cycle after LOAD entry and falls together with the `done` pulse.
- Reset mid-load:
  - all state, the FIFO and `mem_req` clear asynchronously;
  - a write in flight is abandoned, and no `done` is produced.
- `load_size` saturates at 24'hFFFFFF.

## Configuration
- `ROMWRITER_HEADER_EN` defined:
  - during a type-1 load, bytes at offsets 0xAC–0xAF are latched into `game_code`;
  - `hdr_valid` sets after offset 0xAF, even if that byte's word was dropped.
- `ROMWRITER_HEADER_EN` undefined: `game_code`=0 and `hdr_valid`=0 permanently, and the capture logic is absent.

## Test plan
- ROM load, 6 bytes 11..66, ack after 2 cycles:
  - writes (0x000000, 0x2211, 11), (0x000002, 0x4433, 11), (0x000004, 0x6655, 11);
  - `load_size`=6; one `done`; `overflow`=0.
- Cart RAM load of 3 bytes AA BB CC:
  - writes (0x700000, 0xBBAA, 11) then (0x700002, 0x00CC, 01);
  - `done` only after the second ack.
- `mem_ack` held low while 40 bytes stream back-to-back with `FIFO_DEPTH`=8:
  - `overflow`=1 and `load_size`=40;
  - after acks resume, exactly 8 writes occur at addresses 0x0..0xE.
- Reset asserted with 3 words queued and `mem_req` high:
  - all outputs go to 0 immediately;
  - a following BIOS load of 2 bytes writes at 0x780000.
- `rom_loading`=3 with 4 strobes:
  - no `mem_req`, `busy`=0, `load_size` unchanged.
- With `ROMWRITER_HEADER_EN`, ROM load of 0xC0 bytes whose value equals the low byte of its offset:
  - `game_code`=32'hAFAEADAC and `hdr_valid`=1;
  - without the macro, both stay 0.
